cpu_clk_ctrl: RTL and testbench

Run-control and clock-enable sequencer for the single-cycle processor core. Produces single-cycle enable pulses for the data-memory and register-file/PC update domains from one system clock. These pulses replace derived clocks. Provides run / halt / single-step control, with halts taken only at instruction boundaries, and keeps a retired-instruction counter for debug.

---
 rtl/cpu_clk_ctrl_if.sv | 43 ++++
 rtl/cpu_clk_ctrl.sv | 117 +++++++++++
 tb/tb_cpu_clk_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_clk_ctrl_if.sv
// Run-control request / status bundle for cpu_clk_ctrl.
// master = debugger or test side that issues requests; slave = the sequencer.
// Optional macro: CPU_CLK_CTRL_BKPT_EN adds the breakpoint signals.
interface cpu_clk_ctrl_if #(
  parameter int REG_DIV = 8,
  parameter int CNT_W   = 32
);
  localparam int PH_W = $clog2(REG_DIV);

  logic             run_req;
  logic             halt_req;
  logic             step_req;
  logic             dmem_en;
  logic             reg_en;
  logic [PH_W-1:0]  phase;
  logic             running;
  logic             halted;
  logic             step_done;
  logic [CNT_W-1:0] instr_cnt;
`ifdef CPU_CLK_CTRL_BKPT_EN
  logic             bkpt_arm;
  logic [CNT_W-1:0] bkpt_cnt;
  logic             bkpt_hit;

  modport master (
    output run_req, halt_req, step_req, bkpt_arm, bkpt_cnt,
    input  dmem_en, reg_en, phase, running, halted, step_done, instr_cnt, bkpt_hit
  );
  modport slave (
    input  run_req, halt_req, step_req, bkpt_arm, bkpt_cnt,
    output dmem_en, reg_en, phase, running, halted, step_done, instr_cnt, bkpt_hit
  );
`else
  modport master (
    output run_req, halt_req, step_req,
    input  dmem_en, reg_en, phase, running, halted, step_done, instr_cnt
  );
  modport slave (
    input  run_req, halt_req, step_req,
    output dmem_en, reg_en, phase, running, halted, step_done, instr_cnt
  );
`endif
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Run / halt / single-step sequencer producing dmem_en and reg_en enable
// pulses from a single clock, plus a retired-instruction counter.
// Optional macro: CPU_CLK_CTRL_BKPT_EN enables the instruction-count breakpoint.
module cpu_clk_ctrl #(
  parameter int REG_DIV  = 8,
  parameter int DMEM_DIV = 2,
  parameter int CNT_W    = 32
) (
  input  logic           clk,
  input  logic           rst,
  cpu_clk_ctrl_if.slave  ctl
);
  localparam int PH_W = $clog2(REG_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(REG_DIV - 1);

  typedef enum logic [1:0] {S_HALT = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             halt_pend_q, halt_pend_d;
  logic             step_done_q, step_done_d;
  logic             reg_en_w, dmem_en_w;
  logic             bkpt_stop;

`ifdef CPU_CLK_CTRL_BKPT_EN
  logic             bkpt_hit_q, bkpt_hit_d;
  // Breakpoint fires only in free-run, on the commit that reaches bkpt_cnt.
  assign bkpt_stop = (state_q == S_RUN) && reg_en_w && ctl.bkpt_arm &&
                     ((instr_cnt_q + CNT_W'(1)) == ctl.bkpt_cnt);
`else
  assign bkpt_stop = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_HALT;
    else      state_q <= state_d;
  end

  // Next-state: halts only take effect at the commit cycle of a period.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALT: begin
        if (ctl.step_req)     state_d = S_STEP;
        else if (ctl.run_req) state_d = S_RUN;
      end
      S_RUN: begin
        if (reg_en_w && (halt_pend_q || ctl.halt_req || bkpt_stop)) state_d = S_HALT;
      end
      S_STEP: begin
        if (reg_en_w) state_d = S_HALT;
      end
      default: state_d = S_HALT;
    endcase
  end

  // Output decode from registered state and phase; all enables dead in HALT.
  always_comb begin
    reg_en_w  = (state_q != S_HALT) && (phase_q == PH_LAST);
    dmem_en_w = (state_q != S_HALT) &&
                ((32'(phase_q) % DMEM_DIV) == (DMEM_DIV - 1));
  end

  // Datapath next values: phase counter, halt latch, retire counter, pulses.
  always_comb begin
    phase_d     = '0;
    halt_pend_d = 1'b0;
    instr_cnt_d = instr_cnt_q;
    step_done_d = (state_q == S_STEP) && reg_en_w;
`ifdef CPU_CLK_CTRL_BKPT_EN
    bkpt_hit_d  = bkpt_stop;
`endif
    if (state_q != S_HALT) begin
      phase_d = reg_en_w ? '0 : phase_q + PH_W'(1);
    end
    if (state_q == S_RUN && !reg_en_w) begin
      halt_pend_d = halt_pend_q || ctl.halt_req;
    end
    if (reg_en_w) begin
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers; reset throws away any partial period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q     <= '0;
      instr_cnt_q <= '0;
      halt_pend_q <= 1'b0;
      step_done_q <= 1'b0;
`ifdef CPU_CLK_CTRL_BKPT_EN
      bkpt_hit_q  <= 1'b0;
`endif
    end else begin
      phase_q     <= phase_d;
      instr_cnt_q <= instr_cnt_d;
      halt_pend_q <= halt_pend_d;
      step_done_q <= step_done_d;
`ifdef CPU_CLK_CTRL_BKPT_EN
      bkpt_hit_q  <= bkpt_hit_d;
`endif
    end
  end

  assign ctl.dmem_en   = dmem_en_w;
  assign ctl.reg_en    = reg_en_w;
  assign ctl.phase     = phase_q;
  assign ctl.running   = (state_q != S_HALT);
  assign ctl.halted    = (state_q == S_HALT);
  assign ctl.step_done = step_done_q;
  assign ctl.instr_cnt = instr_cnt_q;
`ifdef CPU_CLK_CTRL_BKPT_EN
  assign ctl.bkpt_hit  = bkpt_hit_q;
`endif
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl (REG_DIV=8, DMEM_DIV=2, CNT_W=32).
// Expected per-cycle outputs are queued when a scenario is set up and popped
// at each falling edge, where the DUT outputs are sampled.
module tb_cpu_clk_ctrl;
  logic clk;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  cpu_clk_ctrl_if #(.REG_DIV(8), .CNT_W(32)) b ();

  cpu_clk_ctrl #(.REG_DIV(8), .DMEM_DIV(2), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        halted;
    logic        running;
    logic        dmem_en;
    logic        reg_en;
    logic [2:0]  phase;
    logic        step_done;
    logic [31:0] cnt;
  } obs_t;

  obs_t sb[$];

  // Expected outputs for a cycle, built from the enable rules for 8/2 division.
  function automatic obs_t mk(input bit h, input int ph, input int cnt, input bit sd);
    obs_t o;
    o.halted    = h;
    o.running   = !h;
    o.phase     = h ? 3'd0 : 3'(ph);
    o.dmem_en   = !h && ((ph % 2) == 1);
    o.reg_en    = !h && (ph == 7);
    o.step_done = sd;
    o.cnt       = 32'(cnt);
    return o;
  endfunction

  function automatic obs_t snap();
    obs_t o;
    o.halted    = b.halted;
    o.running   = b.running;
    o.dmem_en   = b.dmem_en;
    o.reg_en    = b.reg_en;
    o.phase     = b.phase;
    o.step_done = b.step_done;
    o.cnt       = b.instr_cnt;
    return o;
  endfunction

  task automatic drive(input bit r, input bit h, input bit s);
    b.run_req  = r;
    b.halt_req = h;
    b.step_req = s;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    for (int i = 0; i < 22; i++) sb.push_back(mk(1, 0, 0, 0));
    #1 rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      got = snap(); exp = sb.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, got, exp);
      end
      if (i == 1) rst = 1'b1;
    end
  endtask

  task automatic test_run();
    obs_t got, exp;
    for (int i = 0; i < 26; i++)
      sb.push_back(i == 0 ? mk(1, 0, 0, 0) : mk(0, (i - 1) % 8, (i - 1) / 8, 0));
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      got = snap(); exp = sb.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL run[%0d] got=%h exp=%h", i, got, exp);
      end
      drive(i == 0, 0, 0);
    end
  endtask

  // Continues from test_run: DUT is running, next observed phase is 1.
  task automatic test_halt();
    obs_t got, exp;
    for (int j = 0; j < 10; j++)
      sb.push_back(j <= 6 ? mk(0, j + 1, 3, 0) : mk(1, 0, 4, 0));
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      got = snap(); exp = sb.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL halt[%0d] got=%h exp=%h", j, got, exp);
      end
      drive(0, j == 1, 0);
    end
  endtask

  // step+run together (step wins); later run/halt during the step are ignored.
  task automatic test_back_to_back();
    obs_t got, exp;
    for (int j = 0; j < 11; j++) begin
      if (j == 0)      sb.push_back(mk(1, 0, 4, 0));
      else if (j <= 8) sb.push_back(mk(0, j - 1, 4, 0));
      else             sb.push_back(mk(1, 0, 5, j == 9));
    end
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      got = snap(); exp = sb.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL step[%0d] got=%h exp=%h", j, got, exp);
      end
      drive(j == 0 || j == 3, j == 4, j == 0);
    end
  endtask

  // halt_req landing in the reg_en cycle itself; halt_req in HALT ignored.
  task automatic test_halt_at_reg_en();
    obs_t got, exp;
    for (int j = 0; j < 11; j++) begin
      if (j == 0)      sb.push_back(mk(1, 0, 5, 0));
      else if (j <= 8) sb.push_back(mk(0, j - 1, 5, 0));
      else             sb.push_back(mk(1, 0, 6, 0));
    end
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      got = snap(); exp = sb.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL halt_edge[%0d] got=%h exp=%h", j, got, exp);
      end
      drive(j == 0, j == 8 || j == 9, 0);
    end
  endtask

  // Reset dropped mid-period at phase 4; visible before the next clock edge.
  task automatic test_async_reset();
    obs_t got, exp;
    sb.push_back(mk(1, 0, 6, 0));
    for (int j = 1; j <= 5; j++) sb.push_back(mk(0, j - 1, 6, 0));
    for (int j = 0; j < 7; j++) sb.push_back(mk(1, 0, 0, 0));
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      got = snap(); exp = sb.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL areset_pre[%0d] got=%h exp=%h", j, got, exp);
      end
      drive(j == 0, 0, 0);
    end
    #1 rst = 1'b0;
    #1;
    got = snap(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL areset_async got=%h exp=%h", got, exp);
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      got = snap(); exp = sb.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL areset_post[%0d] got=%h exp=%h", j, got, exp);
      end
      if (j == 1) rst = 1'b1;
    end
  endtask

`ifdef CPU_CLK_CTRL_BKPT_EN
  task automatic test_bkpt();
    obs_t got, exp;
    logic hit;
    b.bkpt_arm = 1'b1;
    b.bkpt_cnt = 32'd3;
    for (int j = 0; j < 27; j++) begin
      if (j == 0)       sb.push_back(mk(1, 0, 0, 0));
      else if (j <= 24) sb.push_back(mk(0, (j - 1) % 8, (j - 1) / 8, 0));
      else              sb.push_back(mk(1, 0, 3, 0));
    end
    for (int j = 0; j < 27; j++) begin
      @(negedge clk);
      got = snap(); exp = sb.pop_front(); hit = b.bkpt_hit; vectors += 2;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL bkpt[%0d] got=%h exp=%h", j, got, exp);
      end
      if (hit !== (j == 25)) begin
        miscompares++;
        $display("FAIL bkpt_hit[%0d] got=%b exp=%b", j, hit, (j == 25));
      end
      drive(j == 0, 0, 0);
    end
    b.bkpt_arm = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0);
`ifdef CPU_CLK_CTRL_BKPT_EN
    b.bkpt_arm = 1'b0;
    b.bkpt_cnt = '0;
`endif
    test_reset();
    test_run();
    test_halt();
    test_back_to_back();
    test_halt_at_reg_en();
    test_async_reset();
`ifdef CPU_CLK_CTRL_BKPT_EN
    test_bkpt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
